// File: rtl/spi_serf.sv
// -----------------------------------------------------------------------------
// spi_serf : SPI responder for the far end of the 16-bit SPI monarch link.
//
// Runs entirely on the system clock and oversamples SCLK, SS_n and MOSI
// (SCLK idles high, CPOL=1/CPHA=1, MSB first). A frame is a command byte
// {R/W_n, addr[6:0]} followed by a data byte. Reads ask the parent for data
// mid-frame via addr/addr_vld/rsp_data. Writes hand addr/wr_data to the parent
// with wr_vld at frame end.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   SS_n       in   serf select, active low (asynchronous)
//   SCLK       in   serial clock, idles high (asynchronous)
//   MOSI       in   serial data from monarch (asynchronous)
//   MISO       out  serial data to monarch
//   addr[6:0]  out  register address from the command byte
//   rnw        out  1 = read, 0 = write
//   addr_vld   out  one-clk pulse when the command byte is complete
//   rsp_data   in   read data from the parent, sampled 1 clk after addr_vld
//   wr_vld     out  one-clk pulse at the end of a valid write frame
//   wr_data    out  data byte of the last write frame
//   rd_done    out  one-clk pulse at the end of a valid read frame
//   frame_err  out  one-clk pulse when a frame ends with a bit count != 16
//
// Build option
//   SPI_SERF_MISO_TRI_EN : when defined, MISO floats (1'bz) while the
//   synced SS_n is high or the block is idle, so several serfs can share
//   one MISO line. When undefined, MISO is always driven from tx_shft[15].
// -----------------------------------------------------------------------------
module spi_serf (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       SS_n,
    input  logic       SCLK,
    input  logic       MOSI,
    output logic       MISO,
    output logic [6:0] addr,
    output logic       rnw,
    output logic       addr_vld,
    input  logic [7:0] rsp_data,
    output logic       wr_vld,
    output logic [7:0] wr_data,
    output logic       rd_done,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_RSP  = 2'd2,
        ST_DATA = 2'd3
    } state_t;

    state_t      state_q, state_d;

    // Synchronizer chains: [0] first stage, [1] synced value, [2] edge history.
    logic [2:0]  sclk_sync_q, sclk_sync_d;
    logic [2:0]  ss_sync_q,   ss_sync_d;
    logic [1:0]  mosi_sync_q, mosi_sync_d;

    // Marks the synchronizer pipeline as refilled from the pins after reset.
    logic [1:0]  fill_q, fill_d;
    logic        armed_q, armed_d;

    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] rx_shft_q, rx_shft_d;
    logic [15:0] tx_shft_q, tx_shft_d;

    logic [6:0]  addr_q, addr_d;
    logic        rnw_q, rnw_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        addr_vld_q, addr_vld_d;
    logic        wr_vld_q, wr_vld_d;
    logic        rd_done_q, rd_done_d;
    logic        frame_err_q, frame_err_d;

    logic        sclk_rise, sclk_fall, ss_rise, ss_fall;

    assign sclk_rise =  sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] &  sclk_sync_q[2];
    assign ss_rise   =  ss_sync_q[1]   & ~ss_sync_q[2];
    assign ss_fall   = ~ss_sync_q[1]   &  ss_sync_q[2];

    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], SCLK};
        ss_sync_d   = {ss_sync_q[1:0], SS_n};
        mosi_sync_d = {mosi_sync_q[0], MOSI};
        fill_d      = {fill_q[0], 1'b1};
    end

    // Next-state and datapath logic.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shft_d   = rx_shft_q;
        tx_shft_d   = tx_shft_q;
        addr_d      = addr_q;
        rnw_d       = rnw_q;
        wr_data_d   = wr_data_q;
        addr_vld_d  = 1'b0;
        wr_vld_d    = 1'b0;
        rd_done_d   = 1'b0;
        frame_err_d = 1'b0;

        // The sync flops reset to 1, so right after reset the synced SS_n
        // reads high even if the pin is low. Only trust it once the pipeline
        // has been refilled from the pin; otherwise a reset released
        // mid-frame would arm immediately and see a bogus SS_n fall.
        armed_d = armed_q | (fill_q[1] & ss_sync_q[1]);

        // SCLK edges are applied before any frame-end evaluation below,
        // which looks at the _d values.
        if (sclk_rise) begin
            rx_shft_d = {rx_shft_q[14:0], mosi_sync_q[1]};
            bit_cnt_d = (bit_cnt_q == 5'd31) ? 5'd31 : bit_cnt_q + 5'd1;
        end
        if (sclk_fall) begin
            tx_shft_d = {tx_shft_q[14:0], 1'b0};
        end

        case (state_q)
            ST_IDLE: begin
                if (ss_fall && armed_q) begin
                    state_d   = ST_CMD;
                    bit_cnt_d = 5'd0;
                    rx_shft_d = 16'h0000;
                    tx_shft_d = 16'h0000;
                end
            end
            ST_CMD: begin
                if (ss_rise) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                end else if (bit_cnt_d == 5'd8) begin
                    state_d    = ST_RSP;
                    addr_d     = rx_shft_d[6:0];
                    rnw_d      = rx_shft_d[7];
                    addr_vld_d = 1'b1;
                end
            end
            ST_RSP: begin
                if (ss_rise) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                end else begin
                    // Bit 15 is left alone: the next SCLK fall moves
                    // rsp_data[7] into the MISO position.
                    state_d         = ST_DATA;
                    tx_shft_d[14:7] = rsp_data;
                end
            end
            ST_DATA: begin
                if (ss_rise) begin
                    state_d = ST_IDLE;
                    if (bit_cnt_d == 5'd16) begin
                        if (rnw_q) begin
                            rd_done_d = 1'b1;
                        end else begin
                            wr_data_d = rx_shft_d[7:0];
                            wr_vld_d  = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= 3'b111;
            ss_sync_q   <= 3'b111;
            mosi_sync_q <= 2'b11;
            fill_q      <= 2'b00;
            armed_q     <= 1'b0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 5'd0;
            rx_shft_q   <= 16'h0000;
            tx_shft_q   <= 16'h0000;
            addr_q      <= 7'd0;
            rnw_q       <= 1'b0;
            wr_data_q   <= 8'd0;
            addr_vld_q  <= 1'b0;
            wr_vld_q    <= 1'b0;
            rd_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            ss_sync_q   <= ss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            fill_q      <= fill_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shft_q   <= rx_shft_d;
            tx_shft_q   <= tx_shft_d;
            addr_q      <= addr_d;
            rnw_q       <= rnw_d;
            wr_data_q   <= wr_data_d;
            addr_vld_q  <= addr_vld_d;
            wr_vld_q    <= wr_vld_d;
            rd_done_q   <= rd_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign addr      = addr_q;
    assign rnw       = rnw_q;
    assign wr_data   = wr_data_q;
    assign addr_vld  = addr_vld_q;
    assign wr_vld    = wr_vld_q;
    assign rd_done   = rd_done_q;
    assign frame_err = frame_err_q;

`ifdef SPI_SERF_MISO_TRI_EN
    assign MISO = (ss_sync_q[1] || (state_q == ST_IDLE)) ? 1'bz : tx_shft_q[15];
`else
    assign MISO = tx_shft_q[15];
`endif

endmodule

// File: tb/tb_spi_serf.sv
// -----------------------------------------------------------------------------
// tb_spi_serf : directed self-checking bench for spi_serf.
// Acts as the SPI monarch (SCLK half period = 8 clk) and as a small parent
// register file. Pulse outputs are counted and time-stamped on the falling
// clk edge; every comparison is an immediate assertion against a
// hand-computed value.
// -----------------------------------------------------------------------------
module tb_spi_serf;

    logic       clk;
    logic       rst_n;
    logic       SS_n;
    logic       SCLK;
    logic       MOSI;
    wire        miso_w;
    logic [6:0] addr;
    logic       rnw;
    logic       addr_vld;
    logic [7:0] rsp_data;
    logic       wr_vld;
    logic [7:0] wr_data;
    logic       rd_done;
    logic       frame_err;

    spi_serf dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (miso_w),
        .addr      (addr),
        .rnw       (rnw),
        .addr_vld  (addr_vld),
        .rsp_data  (rsp_data),
        .wr_vld    (wr_vld),
        .wr_data   (wr_data),
        .rd_done   (rd_done),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Parent register file: combinational lookup on addr.
    always_comb begin
        case (addr)
            7'h0F:   rsp_data = 8'h6A;
            7'h26:   rsp_data = 8'h5C;
            7'h27:   rsp_data = 8'hC3;
            default: rsp_data = 8'h00;
        endcase
    end

    // Cycle counter and pulse monitor.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         av_cnt = 0, wv_cnt = 0, rd_cnt = 0, fe_cnt = 0;
    int         av_cyc = 0, rd_cyc = 0, fe_cyc = 0, wv_cyc = 0;
    logic [6:0] av_addr = '0, wv_addr = '0;
    logic       av_rnw = 1'b0;
    logic [7:0] wv_data = '0;
    logic [6:0] rd_log [8];

    always @(negedge clk) begin
        if (addr_vld === 1'b1) begin
            av_cnt  = av_cnt + 1;
            av_cyc  = cyc;
            av_addr = addr;
            av_rnw  = rnw;
        end
        if (wr_vld === 1'b1) begin
            wv_cnt  = wv_cnt + 1;
            wv_cyc  = cyc;
            wv_addr = addr;
            wv_data = wr_data;
        end
        if (rd_done === 1'b1) begin
            rd_log[rd_cnt % 8] = addr;
            rd_cnt = rd_cnt + 1;
            rd_cyc = cyc;
        end
        if (frame_err === 1'b1) begin
            fe_cnt = fe_cnt + 1;
            fe_cyc = cyc;
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    int last_rise_cyc = 0;
    int rise8_cyc     = 0;
    int ss_rise_cyc   = 0;

    // One SCLK period: fall (monarch drives MOSI), then rise (monarch samples MISO).
    task automatic sbit(input logic b, output logic m);
        SCLK = 1'b0;
        MOSI = b;
        repeat (8) @(negedge clk);
        SCLK = 1'b1;
        last_rise_cyc = cyc;
        m = miso_w;
        repeat (8) @(negedge clk);
    endtask

    task automatic frame(input logic [15:0] d, input int nbits, input int gap,
                         output logic [15:0] r);
        logic m;
        r = 16'h0000;
        SS_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            sbit(d[15-i], m);
            r[15-i] = m;
            if (i == 7) rise8_cyc = last_rise_cyc;
        end
        SS_n = 1'b1;
        ss_rise_cyc = cyc;
        repeat (gap) @(negedge clk);
    endtask

    // Watchdog: the directed sequence needs a few thousand clks.
    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    logic        idle_miso_exp;
    logic [15:0] r;
    logic        m;
    int          s_av, s_wv, s_rd, s_fe;
    logic [15:0] mid_cmd;

    initial begin
`ifdef SPI_SERF_MISO_TRI_EN
        idle_miso_exp = 1'bz;
`else
        idle_miso_exp = 1'b0;
`endif
        rst_n = 1'b0;
        SS_n  = 1'b1;
        SCLK  = 1'b1;
        MOSI  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_addr",      {25'd0, addr},      32'h0);
        chk("rst_rnw",       {31'd0, rnw},       32'h0);
        chk("rst_wr_data",   {24'd0, wr_data},   32'h0);
        chk("rst_addr_vld",  {31'd0, addr_vld},  32'h0);
        chk("rst_wr_vld",    {31'd0, wr_vld},    32'h0);
        chk("rst_rd_done",   {31'd0, rd_done},   32'h0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'h0);
        chk("rst_miso",      {31'd0, miso_w},    {31'd0, idle_miso_exp});
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // WHO_AM_I read
        s_av = av_cnt; s_wv = wv_cnt; s_rd = rd_cnt; s_fe = fe_cnt;
        frame(16'h8F00, 16, 12, r);
        chk("whoami_rd_data",  {16'd0, r},         32'h0000_006A);
        chk("whoami_av_cnt",   av_cnt - s_av,      32'd1);
        chk("whoami_addr",     {25'd0, av_addr},   32'h0F);
        chk("whoami_rnw",      {31'd0, av_rnw},    32'h1);
        chk("whoami_av_lat",   av_cyc - rise8_cyc, 32'd3);
        chk("whoami_rd_cnt",   rd_cnt - s_rd,      32'd1);
        chk("whoami_rd_lat",   rd_cyc - ss_rise_cyc, 32'd3);
        chk("whoami_wv_cnt",   wv_cnt - s_wv,      32'd0);
        chk("whoami_fe_cnt",   fe_cnt - s_fe,      32'd0);
        chk("whoami_idle_miso", {31'd0, miso_w},   {31'd0, idle_miso_exp});

        // Write 0x0D02
        s_av = av_cnt; s_wv = wv_cnt; s_rd = rd_cnt; s_fe = fe_cnt;
        frame(16'h0D02, 16, 12, r);
        chk("wr_wv_cnt",  wv_cnt - s_wv,        32'd1);
        chk("wr_addr",    {25'd0, wv_addr},     32'h0D);
        chk("wr_data",    {24'd0, wv_data},     32'h02);
        chk("wr_rnw",     {31'd0, av_rnw},      32'h0);
        chk("wr_wv_lat",  wv_cyc - ss_rise_cyc, 32'd3);
        chk("wr_rd_cnt",  rd_cnt - s_rd,        32'd0);
        chk("wr_fe_cnt",  fe_cnt - s_fe,        32'd0);
        chk("wr_hold",    {24'd0, wr_data},     32'h02);

        // Back-to-back reads with a 2-clk SS_n gap
        s_av = av_cnt; s_wv = wv_cnt; s_rd = rd_cnt; s_fe = fe_cnt;
        frame(16'hA600, 16, 2, r);
        chk("b2b_rd_data0", {16'd0, r}, 32'h0000_005C);
        frame(16'hA700, 16, 12, r);
        chk("b2b_rd_data1", {16'd0, r}, 32'h0000_00C3);
        chk("b2b_rd_cnt",   rd_cnt - s_rd,                 32'd2);
        chk("b2b_rd_addr0", {25'd0, rd_log[s_rd % 8]},     32'h26);
        chk("b2b_rd_addr1", {25'd0, rd_log[(s_rd+1) % 8]}, 32'h27);
        chk("b2b_fe_cnt",   fe_cnt - s_fe,                 32'd0);

        // Short frame (12 SCLK rises), then a normal write
        s_av = av_cnt; s_wv = wv_cnt; s_rd = rd_cnt; s_fe = fe_cnt;
        frame(16'h0D0F, 12, 12, r);
        chk("short_fe_cnt", fe_cnt - s_fe,        32'd1);
        chk("short_fe_lat", fe_cyc - ss_rise_cyc, 32'd3);
        chk("short_wv_cnt", wv_cnt - s_wv,        32'd0);
        chk("short_rd_cnt", rd_cnt - s_rd,        32'd0);
        frame(16'h1155, 16, 12, r);
        chk("after_short_wv_cnt", wv_cnt - s_wv,    32'd1);
        chk("after_short_addr",   {25'd0, wv_addr}, 32'h11);
        chk("after_short_data",   {24'd0, wv_data}, 32'h55);
        chk("after_short_fe_cnt", fe_cnt - s_fe,    32'd1);

        // Reset during the data byte of a read, released with SS_n low
        mid_cmd = 16'h8F00;
        SS_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 10; i++) sbit(mid_cmd[15-i], m);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_addr",    {25'd0, addr},    32'h0);
        chk("midrst_rnw",     {31'd0, rnw},     32'h0);
        chk("midrst_wr_data", {24'd0, wr_data}, 32'h0);
        chk("midrst_miso",    {31'd0, miso_w},  {31'd0, idle_miso_exp});
        rst_n = 1'b1;
        s_av = av_cnt; s_wv = wv_cnt; s_rd = rd_cnt; s_fe = fe_cnt;
        for (int i = 10; i < 16; i++) sbit(mid_cmd[15-i], m);
        SS_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("midrst_av_cnt", av_cnt - s_av, 32'd0);
        chk("midrst_wv_cnt", wv_cnt - s_wv, 32'd0);
        chk("midrst_rd_cnt", rd_cnt - s_rd, 32'd0);
        chk("midrst_fe_cnt", fe_cnt - s_fe, 32'd0);
        frame(16'h8F00, 16, 12, r);
        chk("postrst_rd_data", {16'd0, r},       32'h0000_006A);
        chk("postrst_rd_cnt",  rd_cnt - s_rd,    32'd1);
        chk("postrst_addr",    {25'd0, av_addr}, 32'h0F);
        chk("postrst_miso",    {31'd0, miso_w},  {31'd0, idle_miso_exp});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
